// File: rtl/tsetlin_pkg.sv
// Shared feedback codes and elaboration-time sizing helpers for the Tsetlin automaton bank.
package tsetlin_pkg;

  localparam logic [1:0] FB_IGNORE  = 2'b00;
  localparam logic [1:0] FB_REWARD  = 2'b01;
  localparam logic [1:0] FB_PENALTY = 2'b10;
  localparam logic [1:0] FB_RSVD    = 2'b11;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of a state register holding 0..2*n_states-1.
  function automatic int state_width(input int n_states);
    return max_int(1, clog2(2 * n_states));
  endfunction

endpackage

// File: rtl/tsetlin_ta_cell.sv
// One two-action Tsetlin automaton with 2*N_STATES states; action decoded from the state register.
module tsetlin_ta_cell
  import tsetlin_pkg::*;
#(
  parameter int N_STATES = 3,
  localparam int SW = state_width(N_STATES)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          INIT,
  input  logic          FB_VALID,
  input  logic [1:0]    FB_TYPE,
  output logic [SW-1:0] STATE,
  output logic          ACTION,
  output logic          ACTION_NXT,
  output logic          FLIP
);

  localparam logic [SW-1:0] S_INIT = SW'(N_STATES - 1);
  localparam logic [SW-1:0] S_MAX  = SW'(2 * N_STATES - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);

  logic [SW-1:0] state_r;
  logic [SW-1:0] upd_s;
  logic [SW-1:0] load_s;
  logic          flip_r;

  function automatic logic include_of(input logic [SW-1:0] s);
    return (int'(s) >= N_STATES);
  endfunction

  assign STATE      = state_r;
  assign ACTION     = include_of(state_r);
  assign ACTION_NXT = include_of(load_s);
  assign FLIP       = flip_r;

  // Feedback rule: reward deepens the current action, penalty moves toward the other one.
  always_comb begin
    upd_s = state_r;
    if (int'(state_r) > 2 * N_STATES - 1) begin
      upd_s = S_INIT;
    end else begin
      case (FB_TYPE)
        FB_REWARD: begin
          if (ACTION) begin
            if (state_r != S_MAX) upd_s = state_r + S_ONE;
            else                  upd_s = state_r;
          end else begin
            if (state_r != '0) upd_s = state_r - S_ONE;
            else               upd_s = state_r;
          end
        end
        FB_PENALTY: begin
          if (ACTION) upd_s = state_r - S_ONE;
          else        upd_s = state_r + S_ONE;
        end
        default: upd_s = state_r;
      endcase
    end
  end

  // Value loaded at the next edge; INIT takes priority over feedback.
  always_comb begin
    load_s = state_r;
    if (INIT)          load_s = S_INIT;
    else if (FB_VALID) load_s = upd_s;
    else               load_s = state_r;
  end

  // State and action-flip registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= S_INIT;
      flip_r  <= 1'b0;
    end else begin
      state_r <= load_s;
      flip_r  <= FB_VALID & ~INIT & (ACTION_NXT ^ ACTION);
    end
  end

endmodule

// File: rtl/tsetlin_automaton_bank.sv
// Bank of NUM_TA independent Tsetlin automata with registered include count and state readback.
module tsetlin_automaton_bank
  import tsetlin_pkg::*;
#(
  parameter int NUM_TA   = 8,
  parameter int N_STATES = 3,
  localparam int SW = state_width(N_STATES),
  localparam int CW = clog2(NUM_TA + 1),
  localparam int IW = max_int(1, clog2(NUM_TA))
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                INIT,
  input  logic                FB_VALID,
  input  logic [2*NUM_TA-1:0] FB_TYPE,
  output logic [NUM_TA-1:0]   ACTION,
  output logic [NUM_TA-1:0]   FLIP,
  output logic [CW-1:0]       INCLUDE_CNT,
  input  logic [IW-1:0]       RD_SEL,
  output logic [SW-1:0]       RD_STATE
);

  logic [SW-1:0]     state_s [NUM_TA];
  logic [NUM_TA-1:0] act_nxt_s;
  logic [CW-1:0]     cnt_nxt_s;
  logic [CW-1:0]     cnt_r;
  logic [SW-1:0]     rd_s;

  for (genvar i = 0; i < NUM_TA; i++) begin : g_ta
    tsetlin_ta_cell #(.N_STATES(N_STATES)) u_cell (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .INIT       (INIT),
      .FB_VALID   (FB_VALID),
      .FB_TYPE    (FB_TYPE[2*i +: 2]),
      .STATE      (state_s[i]),
      .ACTION     (ACTION[i]),
      .ACTION_NXT (act_nxt_s[i]),
      .FLIP       (FLIP[i])
    );
  end

  // Popcount of the actions that will be loaded, so the count is coherent with ACTION.
  always_comb begin
    cnt_nxt_s = '0;
    for (int i = 0; i < NUM_TA; i++) begin
      cnt_nxt_s = cnt_nxt_s + CW'(act_nxt_s[i]);
    end
  end

  // Include-count register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_r <= '0;
    else        cnt_r <= cnt_nxt_s;
  end

  assign INCLUDE_CNT = cnt_r;

  // Readback mux; indices beyond the bank read as zero.
  always_comb begin
    rd_s = '0;
    for (int i = 0; i < NUM_TA; i++) begin
      if (int'(RD_SEL) == i) rd_s = state_s[i];
    end
  end

  assign RD_STATE = rd_s;

endmodule

// File: tb/tb_tsetlin_automaton_bank.sv
// Self-checking bench: directed vector table, hand sequences, and randomized traffic against a model.
module tb_tsetlin_automaton_bank;

  localparam int NT = 4;
  localparam int N  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init;
  logic        fb_valid;
  logic [7:0]  fb_type;
  logic [3:0]  action;
  logic [3:0]  flip;
  logic [2:0]  include_cnt;
  logic [1:0]  rd_sel;
  logic [2:0]  rd_state;

  // second bank: three single-state-per-half automata
  logic        b_init;
  logic        b_valid;
  logic [5:0]  b_fb;
  logic [2:0]  b_action;
  logic [2:0]  b_flip;
  logic [1:0]  b_cnt;
  logic [1:0]  b_sel;
  logic [0:0]  b_state;

  int n_checks = 0;
  int n_fail   = 0;

  int         m_st [NT];
  logic [3:0] m_flip;

  typedef struct {
    logic        init;
    logic        valid;
    logic [7:0]  fb;
    logic [11:0] st;
    logic [3:0]  act;
    logic [3:0]  flp;
    int          cnt;
  } vec_t;

  vec_t vecs[$];

  always #10 clk = ~clk;

  tsetlin_automaton_bank #(.NUM_TA(NT), .N_STATES(N)) dut (
    .CLK(clk), .RST_N(rst_n), .INIT(init), .FB_VALID(fb_valid), .FB_TYPE(fb_type),
    .ACTION(action), .FLIP(flip), .INCLUDE_CNT(include_cnt), .RD_SEL(rd_sel), .RD_STATE(rd_state)
  );

  tsetlin_automaton_bank #(.NUM_TA(3), .N_STATES(1)) dut_b (
    .CLK(clk), .RST_N(rst_n), .INIT(b_init), .FB_VALID(b_valid), .FB_TYPE(b_fb),
    .ACTION(b_action), .FLIP(b_flip), .INCLUDE_CNT(b_cnt), .RD_SEL(b_sel), .RD_STATE(b_state)
  );

  task automatic chk(input string name, input int idx, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic i_init, input logic i_valid, input logic [7:0] i_fb,
                     input int s3, input int s2, input int s1, input int s0,
                     input logic [3:0] i_act, input logic [3:0] i_flp, input int i_cnt);
    vec_t v;
    v.init  = i_init;
    v.valid = i_valid;
    v.fb    = i_fb;
    v.st    = {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
    v.act   = i_act;
    v.flp   = i_flp;
    v.cnt   = i_cnt;
    vecs.push_back(v);
  endtask

  // Reference: each automaton's state as an integer 0..2N-1, rules applied arithmetically.
  task automatic model_apply(input logic i_init, input logic i_valid, input logic [7:0] i_fb);
    for (int i = 0; i < NT; i++) begin
      int  old_s;
      int  new_s;
      int  code;
      bit  was_inc;
      old_s   = m_st[i];
      new_s   = old_s;
      code    = int'(i_fb[2*i +: 2]);
      was_inc = (old_s >= N);
      if (i_init) begin
        new_s = N - 1;
        m_flip[i] = 1'b0;
      end else if (i_valid) begin
        if (code == 1)      new_s = was_inc ? ((old_s + 1 > 2*N - 1) ? 2*N - 1 : old_s + 1)
                                            : ((old_s - 1 < 0) ? 0 : old_s - 1);
        else if (code == 2) new_s = was_inc ? old_s - 1 : old_s + 1;
        m_flip[i] = (was_inc != (new_s >= N));
      end else begin
        m_flip[i] = 1'b0;
      end
      m_st[i] = new_s;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) m_st[i] = N - 1;
    m_flip = 4'b0000;
  endtask

  task automatic check_model(input int tag);
    logic [3:0] m_act;
    int         m_cnt;
    m_cnt = 0;
    for (int i = 0; i < NT; i++) begin
      m_act[i] = (m_st[i] >= N);
      if (m_st[i] >= N) m_cnt++;
    end
    chk("rnd_action", tag, int'(action), int'(m_act));
    chk("rnd_flip", tag, int'(flip), int'(m_flip));
    chk("rnd_cnt", tag, int'(include_cnt), m_cnt);
    for (int i = 0; i < NT; i++) begin
      rd_sel = 2'(i);
      #1;
      chk("rnd_state", tag * 4 + i, int'(rd_state), m_st[i]);
    end
  endtask

  task automatic b_step(input logic [5:0] fb, input logic [2:0] e_act, input logic [2:0] e_flp,
                        input int e_cnt, input int tag);
    b_valid = 1'b1;
    b_fb    = fb;
    step();
    chk("n1_action", tag, int'(b_action), int'(e_act));
    chk("n1_flip", tag, int'(b_flip), int'(e_flp));
    chk("n1_cnt", tag, int'(b_cnt), e_cnt);
    b_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; init = 1'b0; fb_valid = 1'b0; fb_type = 8'h00; rd_sel = 2'd0;
    b_init = 1'b0; b_valid = 1'b0; b_fb = 6'b0; b_sel = 2'd0;
    model_reset();
    step();
    step();
    // reset state
    chk("rst_action", 0, int'(action), 0);
    chk("rst_flip", 0, int'(flip), 0);
    chk("rst_cnt", 0, int'(include_cnt), 0);
    for (int i = 0; i < NT; i++) begin
      rd_sel = 2'(i);
      #1;
      chk("rst_state", i, int'(rd_state), N - 1);
    end
    #2 rst_n = 1'b1;

    // N_STATES = 1 bank: reward never moves, penalty always flips
    b_step(6'b10_01_01, 3'b100, 3'b100, 1, 0);
    b_step(6'b01_01_10, 3'b101, 3'b001, 2, 1);
    b_step(6'b10_10_10, 3'b010, 3'b111, 1, 2);
    b_sel = 2'd1; #1 chk("n1_rd", 1, int'(b_state), 1);
    b_sel = 2'd0; #1 chk("n1_rd", 0, int'(b_state), 0);
    b_sel = 2'd3; #1 chk("n1_rd_oob", 3, int'(b_state), 0);

    // directed table: init, penalty, rewards, exclude saturation, mixed, hold, init override
    add(1'b1, 1'b0, 8'b00_00_00_00, 2, 2, 2, 2, 4'b0000, 4'b0000, 0);
    add(1'b0, 1'b1, 8'b00_00_00_10, 2, 2, 2, 3, 4'b0001, 4'b0001, 1);
    add(1'b0, 1'b1, 8'b00_00_00_01, 2, 2, 2, 4, 4'b0001, 4'b0000, 1);
    add(1'b0, 1'b1, 8'b00_00_00_01, 2, 2, 2, 5, 4'b0001, 4'b0000, 1);
    for (int k = 0; k < 4; k++)
      add(1'b0, 1'b1, 8'b00_00_00_01, 2, 2, 2, 5, 4'b0001, 4'b0000, 1);
    add(1'b0, 1'b1, 8'b00_00_01_00, 2, 2, 1, 5, 4'b0001, 4'b0000, 1);
    add(1'b0, 1'b1, 8'b00_00_01_00, 2, 2, 0, 5, 4'b0001, 4'b0000, 1);
    add(1'b0, 1'b1, 8'b00_00_01_00, 2, 2, 0, 5, 4'b0001, 4'b0000, 1);
    add(1'b0, 1'b1, 8'b00_00_10_00, 2, 2, 1, 5, 4'b0001, 4'b0000, 1);
    add(1'b0, 1'b1, 8'b00_00_10_00, 2, 2, 2, 5, 4'b0001, 4'b0000, 1);
    add(1'b0, 1'b1, 8'b00_00_10_00, 2, 2, 3, 5, 4'b0011, 4'b0010, 2);
    add(1'b1, 1'b1, 8'b10_10_10_10, 2, 2, 2, 2, 4'b0000, 4'b0000, 0);
    add(1'b0, 1'b1, 8'b10_00_10_00, 3, 2, 3, 2, 4'b1010, 4'b1010, 2);
    add(1'b0, 1'b1, 8'b11_00_10_01, 3, 2, 2, 1, 4'b1000, 4'b0010, 1);
    add(1'b0, 1'b0, 8'b10_10_10_10, 3, 2, 2, 1, 4'b1000, 4'b0000, 1);
    add(1'b0, 1'b1, 8'b01_10_00_00, 4, 3, 2, 1, 4'b1100, 4'b0100, 2);
    add(1'b1, 1'b1, 8'b10_10_10_10, 2, 2, 2, 2, 4'b0000, 4'b0000, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      vec_t v;
      v = vecs[k];
      init = v.init; fb_valid = v.valid; fb_type = v.fb;
      model_apply(v.init, v.valid, v.fb);
      step();
      chk("tbl_action", k, int'(action), int'(v.act));
      chk("tbl_flip", k, int'(flip), int'(v.flp));
      chk("tbl_cnt", k, int'(include_cnt), v.cnt);
      for (int i = 0; i < NT; i++) begin
        rd_sel = 2'(i);
        #1;
        chk("tbl_state", k * 4 + i, int'(rd_state), int'(v.st[3*i +: 3]));
      end
    end

    // asynchronous reset in the middle of a cycle with penalties pending
    init = 1'b0; fb_valid = 1'b1; fb_type = 8'b10_10_10_10;
    model_apply(1'b0, 1'b1, fb_type);
    step();
    check_model(900);
    #3 rst_n = 1'b0;
    #1;
    chk("async_action", 0, int'(action), 0);
    chk("async_flip", 0, int'(flip), 0);
    chk("async_cnt", 0, int'(include_cnt), 0);
    chk("async_state", 0, int'(rd_state), N - 1);
    step();
    chk("async_hold_state", 0, int'(rd_state), N - 1);
    #2 rst_n = 1'b1;
    model_reset();
    fb_valid = 1'b0;
    step();
    check_model(901);

    // randomized traffic against the model
    for (int c = 0; c < 300; c++) begin
      init     = ($urandom_range(0, 15) == 0);
      fb_valid = ($urandom_range(0, 3) != 0);
      fb_type  = 8'($urandom);
      model_apply(init, fb_valid, fb_type);
      step();
      check_model(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
